// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
//
// Hazard controller for the ID -> EX -> MEM section of the RV32IC pipeline.
// It decides, every cycle, whether the front end must hold, whether EX gets a
// bubble, whether the wrong path is squashed after a taken jump/branch, and
// which source the EX-stage ALU uses for operands A and B.
//
// Priority of the per-cycle decision (highest first):
//   data-memory busy > taken jump > post-redirect flush > load-use > run
//
// Ports
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_id_*                       ID-stage instruction: valid, rs1/rs2, use flags
//   i_ex_*                       EX-stage instruction: valid, rd, RegWrite, MemRead
//   i_mem_*                      MEM-stage instruction: rd, RegWrite, valid
//   i_jmp, i_jmp_pc              ALU taken jump/branch and its target
//   i_mem_busy                   data memory not ready
//   o_stall_if, o_stall_id       hold PC and IF/ID
//   o_stall_ex                   hold ID/EX and EX/MEM (memory wait)
//   o_bubble_ex                  load a NOP into ID/EX at the next edge
//   o_flush_if, o_flush_id       invalidate IF/ID and ID/EX contents
//   o_pc_load, o_pc_next         PC redirect strobe and target
//   o_fwd_a, o_fwd_b             operand select: 0 regfile, 1 MEM ALU out, 2 WB
//   o_state                      0 RUN, 1 FLUSH, 2 MEMWAIT
//   o_stall_cnt, o_flush_cnt     saturating performance counters
// ----------------------------------------------------------------------------
module ex_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic              i_ex_valid,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_RegWrite,
    input  logic              i_ex_MemRead,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_RegWrite,
    input  logic              i_mem_valid,
    input  logic              i_jmp,
    input  logic [31:0]       i_jmp_pc,
    input  logic              i_mem_busy,
    output logic              o_stall_if,
    output logic              o_stall_id,
    output logic              o_stall_ex,
    output logic              o_bubble_ex,
    output logic              o_flush_if,
    output logic              o_flush_id,
    output logic              o_pc_load,
    output logic [31:0]       o_pc_next,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic [1:0]        o_state,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    // FLUSH_CYCLES is limited to 1..15, so four bits hold the refill count.
    localparam int FC_W = 4;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    state_t            state_q, state_d;
    state_t            eff_state;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              jmp_taken;
    logic              load_use;
    logic              ex_writes;
    logic              mem_writes;

    logic              stall_if, stall_id, stall_ex, bubble_ex;
    logic              flush_if, flush_id, pc_load;
    logic [31:0]       pc_next;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : (v + one);
    endfunction

    // Forwarding source for one operand. x0 is hard-wired zero and never
    // forwards; the younger producer in EX wins over the one in MEM.
    function automatic logic [1:0] fwd_sel(
        input logic              use_rs,
        input logic [REG_AW-1:0] rs,
        input logic              ex_ok,
        input logic [REG_AW-1:0] ex_rd,
        input logic              mem_ok,
        input logic [REG_AW-1:0] mem_rd
    );
        if (!use_rs || (rs == '0)) begin
            return FWD_RF;
        end
        if (ex_ok && (rs == ex_rd)) begin
            return FWD_MEM;
        end
        if (mem_ok && (rs == mem_rd)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign jmp_taken  = i_jmp & i_ex_valid;
    assign ex_writes  = i_ex_valid & i_ex_RegWrite;
    assign mem_writes = i_mem_valid & i_mem_RegWrite;

    assign load_use = i_ex_valid & i_ex_MemRead & i_ex_RegWrite &
                      (i_ex_rd != '0) & i_id_valid &
                      ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

    // Leaving MEMWAIT resumes whatever mode was interrupted: a nonzero refill
    // count means the wait began inside a flush window. The resumed mode is
    // evaluated in the same cycle busy drops.
    always_comb begin
        eff_state = state_q;
        if (state_q == ST_MEMWAIT) begin
            eff_state = (fcnt_q != '0) ? ST_FLUSH : ST_RUN;
        end
    end

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        pc_load     = 1'b0;
        pc_next     = 32'd0;
        state_d     = eff_state;
        fcnt_d      = fcnt_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (i_reset) begin
            // Every control output stays low; registers clear in always_ff.
            state_d     = ST_RUN;
            fcnt_d      = '0;
            fwd_a_d     = FWD_RF;
            fwd_b_d     = FWD_RF;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else if (i_mem_busy) begin
            // Freeze everything; a pending jump is re-presented once EX moves.
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            stall_ex    = 1'b1;
            state_d     = ST_MEMWAIT;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            if (jmp_taken) begin
                pc_load     = 1'b1;
                pc_next     = i_jmp_pc;
                flush_if    = 1'b1;
                flush_id    = 1'b1;
                flush_cnt_d = sat_inc(flush_cnt_q);
                if (FLUSH_CYCLES > 1) begin
                    fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                    state_d = ST_FLUSH;
                end else begin
                    fcnt_d  = '0;
                    state_d = ST_RUN;
                end
            end else if (eff_state == ST_FLUSH) begin
                // Instructions arriving in ID are still wrong-path fetches.
                flush_id = 1'b1;
                if (fcnt_q <= FC_W'(1)) begin
                    fcnt_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    fcnt_d  = fcnt_q - FC_W'(1);
                    state_d = ST_FLUSH;
                end
            end else if (load_use) begin
                // One bubble suffices: next cycle the load sits in MEM and
                // its result is reachable through the WB forward path.
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                bubble_ex   = 1'b1;
                stall_cnt_d = sat_inc(stall_cnt_q);
                state_d     = ST_RUN;
            end else begin
                state_d = ST_RUN;
            end

            // Selects follow the instruction entering EX; a bubble or a
            // squashed slot reads nothing, so it gets the regfile path.
            if (bubble_ex || flush_id) begin
                fwd_a_d = FWD_RF;
                fwd_b_d = FWD_RF;
            end else begin
                fwd_a_d = fwd_sel(i_id_use_rs1, i_id_rs1, ex_writes, i_ex_rd,
                                  mem_writes, i_mem_rd);
                fwd_b_d = fwd_sel(i_id_use_rs2, i_id_rs2, ex_writes, i_ex_rd,
                                  mem_writes, i_mem_rd);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_if  = stall_if;
    assign o_stall_id  = stall_id;
    assign o_stall_ex  = stall_ex;
    assign o_bubble_ex = bubble_ex;
    assign o_flush_if  = flush_if;
    assign o_flush_id  = flush_id;
    assign o_pc_load   = pc_load;
    assign o_pc_next   = pc_next;
    assign o_fwd_a     = fwd_a_q;
    assign o_fwd_b     = fwd_b_q;
    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

    localparam int REG_AW       = 5;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 6;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              id_valid, use1, use2;
    logic [REG_AW-1:0] rs1, rs2, ex_rd, mem_rd;
    logic              ex_valid, ex_rw, ex_mr, mem_rw, mem_valid;
    logic              jmp, busy;
    logic [31:0]       jmp_pc;

    logic              stall_if, stall_id, stall_ex, bubble_ex;
    logic              flush_if, flush_id, pc_load;
    logic [31:0]       pc_next;
    logic [1:0]        fwd_a, fwd_b, state;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    ex_hazard_ctrl #(
        .REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_use_rs1(use1), .i_id_use_rs2(use2),
        .i_ex_valid(ex_valid), .i_ex_rd(ex_rd),
        .i_ex_RegWrite(ex_rw), .i_ex_MemRead(ex_mr),
        .i_mem_rd(mem_rd), .i_mem_RegWrite(mem_rw), .i_mem_valid(mem_valid),
        .i_jmp(jmp), .i_jmp_pc(jmp_pc), .i_mem_busy(busy),
        .o_stall_if(stall_if), .o_stall_id(stall_id), .o_stall_ex(stall_ex),
        .o_bubble_ex(bubble_ex), .o_flush_if(flush_if), .o_flush_id(flush_id),
        .o_pc_load(pc_load), .o_pc_next(pc_next),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_state(state),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending wrong-path slots, whether the last cycle was a
    // memory wait, current selects and event counts as plain integers.
    int m_rem, m_fa, m_fb, m_sc, m_fc;
    bit m_mw;
    bit m_known = 1'b0;

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic int fsel(input bit use_rs, input int rs);
        if (!use_rs || rs == 0) return 0;
        if (ex_valid && ex_rw && rs == int'(ex_rd)) return 1;
        if (mem_valid && mem_rw && rs == int'(mem_rd)) return 2;
        return 0;
    endfunction

    task automatic clear_inputs();
        rst = 0; id_valid = 0; use1 = 0; use2 = 0; rs1 = 0; rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_rw = 0; ex_mr = 0;
        mem_rd = 0; mem_rw = 0; mem_valid = 0;
        jmp = 0; jmp_pc = 0; busy = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        logic [6:0]  e_ctl;
        logic [31:0] e_pc;
        int n_rem, n_fa, n_fb, n_sc, n_fc, e_state;
        bit n_mw, taken, lu;
        #1;
        e_ctl = '0; e_pc = '0;
        n_rem = m_rem; n_fa = m_fa; n_fb = m_fb; n_sc = m_sc; n_fc = m_fc; n_mw = m_mw;
        if (rst) begin
            n_rem = 0; n_fa = 0; n_fb = 0; n_sc = 0; n_fc = 0; n_mw = 0;
        end else if (busy) begin
            e_ctl = 7'b1110000;
            n_mw  = 1;
            n_sc  = sat(m_sc);
        end else begin
            n_mw  = 0;
            taken = jmp && ex_valid;
            lu = ex_valid && ex_mr && ex_rw && ex_rd != 0 && id_valid &&
                 ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
            if (taken) begin
                e_ctl = 7'b0000111;
                e_pc  = jmp_pc;
                n_rem = FLUSH_CYCLES - 1;
                n_fc  = sat(m_fc);
            end else if (m_rem > 0) begin
                e_ctl = 7'b0000010;
                n_rem = m_rem - 1;
            end else if (lu) begin
                e_ctl = 7'b1101000;
                n_sc  = sat(m_sc);
            end
            if (e_ctl[3] || e_ctl[1]) begin
                n_fa = 0; n_fb = 0;
            end else begin
                n_fa = fsel(use1, int'(rs1));
                n_fb = fsel(use2, int'(rs2));
            end
        end
        if (m_known) begin
            e_state = m_mw ? 2 : ((m_rem > 0) ? 1 : 0);
            check_val("state", 32'(state), 32'(e_state));
            check_val("fwd_a", 32'(fwd_a), 32'(m_fa));
            check_val("fwd_b", 32'(fwd_b), 32'(m_fb));
            check_val("stall_cnt", 32'(stall_cnt), 32'(m_sc));
            check_val("flush_cnt", 32'(flush_cnt), 32'(m_fc));
        end
        if (m_known || rst) begin
            check_val("ctl", 32'({stall_if, stall_id, stall_ex, bubble_ex,
                                  flush_if, flush_id, pc_load}), 32'(e_ctl));
            check_val("pc_next", pc_next, e_pc);
        end
        @(posedge clk);
        m_rem = n_rem; m_fa = n_fa; m_fb = n_fb; m_sc = n_sc; m_fc = n_fc; m_mw = n_mw;
        if (rst) m_known = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        m_rem = 0; m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0; m_mw = 0;
        @(negedge clk);

        // Reset
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);

        // Load-use: LW x5 in EX, ID reads x5
        clear_inputs();
        ex_valid = 1; ex_rd = 5; ex_mr = 1; ex_rw = 1;
        id_valid = 1; use1 = 1; rs1 = 5;
        #1 check_val("lu_stall", 32'({stall_if, stall_id, bubble_ex}), 32'b111);
        cycle();
        ex_valid = 0; ex_mr = 0; ex_rw = 0;
        mem_valid = 1; mem_rd = 5; mem_rw = 1;
        #1 check_val("lu_once", 32'({stall_if, stall_id, bubble_ex}), 32'b000);
        cycle();
        check_val("lu_fwd_a", 32'(fwd_a), 32'd2);
        check_val("lu_cnt", 32'(stall_cnt), 32'd1);

        // ALU forwarding: EX beats MEM; x0 never forwards
        clear_inputs();
        ex_valid = 1; ex_rd = 3; ex_rw = 1;
        mem_valid = 1; mem_rd = 3; mem_rw = 1;
        id_valid = 1; use2 = 1; rs2 = 3;
        cycle();
        check_val("alu_fwd_b", 32'(fwd_b), 32'd1);
        ex_rd = 0; mem_rd = 0; rs2 = 0;
        #1 check_val("x0_nostall", 32'(stall_if), 32'd0);
        cycle();
        check_val("x0_fwd_b", 32'(fwd_b), 32'd0);

        // Taken branch to 0x120
        clear_inputs();
        ex_valid = 1; jmp = 1; jmp_pc = 32'h0000_0120;
        #1 check_val("br_pc", pc_next, 32'h120);
        cycle();
        jmp = 0;
        check_val("br_state1", 32'(state), 32'd1);
        #1 check_val("br_flush", 32'({flush_if, flush_id, pc_load}), 32'b010);
        cycle();
        check_val("br_state0", 32'(state), 32'd0);
        check_val("br_fcnt", 32'(flush_cnt), 32'd1);

        // Memory wait with a pending jump
        clear_inputs();
        rst = 1;
        cycle();
        rst = 0;
        busy = 1; jmp = 1; ex_valid = 1; jmp_pc = 32'h0000_0200;
        for (int k = 0; k < 3; k++) begin
            #1 check_val("mw_ctl", 32'({stall_if, stall_id, stall_ex, pc_load}), 32'b1110);
            cycle();
            check_val("mw_state", 32'(state), 32'd2);
        end
        busy = 0;
        #1 check_val("mw_pcload", 32'(pc_load), 32'd1);
        cycle();
        check_val("mw_scnt", 32'(stall_cnt), 32'd3);

        // Load-use presented in FLUSH is ignored
        clear_inputs();
        ex_valid = 1; ex_mr = 1; ex_rw = 1; ex_rd = 7;
        id_valid = 1; use1 = 1; rs1 = 7;
        #1 check_val("fl_lu", 32'({stall_if, bubble_ex, flush_id}), 32'b001);
        cycle();

        // Reset mid-FLUSH
        clear_inputs();
        ex_valid = 1; jmp = 1; jmp_pc = 32'h0000_0040;
        cycle();
        rst = 1;
        #1 check_val("rst_ctl", 32'({stall_if, stall_id, stall_ex, bubble_ex,
                                     flush_if, flush_id, pc_load}), 32'd0);
        cycle();
        rst = 0;
        check_val("rst_fl_state", 32'(state), 32'd0);
        check_val("rst_fl_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            id_valid  = ($urandom_range(0, 9) != 0);
            use1      = 1'($urandom_range(0, 1));
            use2      = 1'($urandom_range(0, 1));
            rs1       = REG_AW'($urandom_range(0, 3));
            rs2       = REG_AW'($urandom_range(0, 3));
            ex_valid  = ($urandom_range(0, 4) != 0);
            ex_rd     = REG_AW'($urandom_range(0, 3));
            ex_rw     = ($urandom_range(0, 9) < 7);
            ex_mr     = ($urandom_range(0, 9) < 4);
            mem_valid = ($urandom_range(0, 4) != 0);
            mem_rd    = REG_AW'($urandom_range(0, 3));
            mem_rw    = ($urandom_range(0, 9) < 7);
            jmp       = ($urandom_range(0, 9) == 0);
            jmp_pc    = $urandom;
            busy      = ($urandom_range(0, 99) < 12);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
